// File: rtl/bus_pkg.sv
// Shared definitions for the three-bus datapath sequencer: opcodes, ALU
// operation codes, controller state encoding and bus register codes.
package bus_pkg;

    // Memory handshake watchdog
    localparam int MEM_TIMEOUT = 255;
    localparam int TIMEOUT_W   = 8;

    // Instruction opcodes (instr[11:8]); 9..E are illegal
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MOV   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_INC   = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JMPZ  = 4'h8;
    localparam logic [3:0] OP_END   = 4'hF;

    // ALU operation codes
    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_INC  = 3'd3;

    // Bus "nothing selected" codes
    localparam logic [3:0] CBUS_NONE = 4'b0000;
    localparam logic [2:0] BBUS_NONE = 3'b000;

    // General-purpose register codes on the C bus (write) and B bus (read).
    // The sequencer passes instruction fields through unchanged; these names
    // exist so datapath and programs agree on the encoding.
    localparam logic [3:0] REG0_C = 4'b0011;
    localparam logic [3:0] REG1_C = 4'b0100;
    localparam logic [3:0] REG2_C = 4'b0101;
    localparam logic [3:0] REG3_C = 4'b0110;
    localparam logic [2:0] REG0_B = 3'b011;
    localparam logic [2:0] REG1_B = 3'b100;
    localparam logic [2:0] REG2_B = 3'b101;
    localparam logic [2:0] REG3_B = 3'b110;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Opcodes 0..8 and F are defined; everything else traps to ERR
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_JMPZ) || (op == OP_END);
    endfunction

    // ALU function for the register-to-register instructions
    function automatic logic [2:0] alu_op_for(input logic [3:0] op);
        logic [2:0] result;
        case (op)
            OP_ADD:  result = ALU_ADD;
            OP_SUB:  result = ALU_SUB;
            OP_INC:  result = ALU_INC;
            default: result = ALU_PASS;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seq_timeout.sv
// Memory-handshake watchdog: counts cycles spent waiting for mem_ready and
// flags the cycle in which the wait would reach LIMIT.
module seq_timeout #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_reg;

    // Wait counter: clear has priority, saturates at the last count before LIMIT
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // The LIMIT-th waiting cycle without mem_ready is the expiry cycle;
    // a mem_ready in that same cycle still wins in the controller.
    assign expired = inc && (count_reg == LAST);

endmodule

// File: rtl/bus_sequencer.sv
// Multi-cycle controller for the three-bus register datapath. Fetches over a
// mem_ready handshake, decodes, then drives bus selects, ALU op and PC
// controls. State changes on posedge so controls are settled before the
// datapath writes registers on negedge.
module bus_sequencer
    import bus_pkg::*;
#(
    parameter int MEM_TIMEOUT_CYCLES = MEM_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] instr,
    input  logic        mem_ready,
    input  logic        z_flag,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [3:0]  cbus_en,
    output logic [2:0]  bbus_en,
    output logic [2:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t     state_reg;
    logic [3:0] opcode_reg;
    logic [3:0] c_sel_reg;
    logic [2:0] b_sel_reg;
    logic       done_reg;

    logic       waiting;
    logic       to_clear;
    logic       to_inc;
    logic       to_expired;

    // instr[3] is a spare bit in the instruction format
    logic       unused_instr_bit;
    assign unused_instr_bit = instr[3];

    // Only FETCH and MEM wait on memory; outside them the counter is held at
    // zero, which also gives the clear-on-entry behaviour for free.
    assign waiting  = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign to_clear = !waiting || mem_ready;
    assign to_inc   = waiting && !mem_ready;

    seq_timeout #(
        .WIDTH (TIMEOUT_W),
        .LIMIT (MEM_TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (to_clear),
        .inc     (to_inc),
        .expired (to_expired)
    );

    // Controller state, latched instruction fields and the HALT-entry pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            opcode_reg <= OP_NOP;
            c_sel_reg  <= CBUS_NONE;
            b_sel_reg  <= BBUS_NONE;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_reg <= ST_DECODE;
                    end else if (to_expired) begin
                        state_reg <= ST_ERR;
                    end
                end
                ST_DECODE: begin
                    opcode_reg <= instr[11:8];
                    c_sel_reg  <= instr[7:4];
                    b_sel_reg  <= instr[2:0];
                    if (instr[11:8] == OP_END) begin
                        state_reg <= ST_HALT;
                        done_reg  <= 1'b1;
                    end else if (!op_is_legal(instr[11:8])) begin
                        state_reg <= ST_ERR;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if ((opcode_reg == OP_LOAD) || (opcode_reg == OP_STORE)) begin
                        state_reg <= ST_MEM;
                    end else begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state_reg <= ST_FETCH;
                    end else if (to_expired) begin
                        state_reg <= ST_ERR;
                    end
                end
                ST_HALT: state_reg <= ST_HALT;
                ST_ERR:  state_reg <= ST_ERR;
                default: state_reg <= ST_ERR;
            endcase
        end
    end

    // Control decode from registered state and latched fields; mem_ready and
    // z_flag only qualify the few controls that depend on them.
    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        cbus_en = CBUS_NONE;
        bbus_en = BBUS_NONE;
        alu_op  = ALU_PASS;
        case (state_reg)
            ST_FETCH: begin
                mem_rd  = 1'b1;
                ir_load = mem_ready;
            end
            ST_DECODE: begin
                pc_inc = 1'b1;
            end
            ST_EXEC: begin
                case (opcode_reg)
                    OP_MOV, OP_ADD, OP_SUB, OP_INC: begin
                        bbus_en = b_sel_reg;
                        cbus_en = c_sel_reg;
                        alu_op  = alu_op_for(opcode_reg);
                    end
                    OP_JMP: begin
                        bbus_en = b_sel_reg;
                        pc_load = 1'b1;
                    end
                    OP_JMPZ: begin
                        bbus_en = b_sel_reg;
                        pc_load = z_flag;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEM: begin
                // LOAD only writes the C bus and STORE only reads the B bus,
                // so a MEM cycle never reads and writes the same register.
                if (opcode_reg == OP_LOAD) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        cbus_en = c_sel_reg;
                    end
                end else begin
                    mem_wr  = 1'b1;
                    bbus_en = b_sel_reg;
                end
            end
            default: begin
            end
        endcase
    end

    // Status flags
    assign busy = (state_reg != ST_IDLE) && (state_reg != ST_HALT) && (state_reg != ST_ERR);
    assign done = done_reg;
    assign err  = (state_reg == ST_ERR);

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: each step drives one clock cycle of
// inputs, queues the expected control vector, and checks it at negedge.
module tb_bus_sequencer;
    import bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] instr;
    logic        mem_ready;
    logic        z_flag;
    logic        mem_rd, mem_wr, ir_load, pc_inc, pc_load;
    logic [3:0]  cbus_en;
    logic [2:0]  bbus_en;
    logic [2:0]  alu_op;
    logic        busy, done, err;

    always #5 clock = ~clock;

    bus_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .instr     (instr),
        .mem_ready (mem_ready),
        .z_flag    (z_flag),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .cbus_en   (cbus_en),
        .bbus_en   (bbus_en),
        .alu_op    (alu_op),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int compared   = 0;
    int mismatched = 0;

    // Packed control vector: {rd,wr,ir_load,pc_inc,pc_load,cbus,bbus,alu,busy,done,err}
    function automatic logic [16:0] ex(input logic rd, input logic wr, input logic ir,
                                       input logic inc, input logic ld,
                                       input logic [3:0] c, input logic [2:0] b,
                                       input logic [2:0] alu, input logic bsy,
                                       input logic dn, input logic er);
        return {rd, wr, ir, inc, ld, c, b, alu, bsy, dn, er};
    endfunction

    task automatic check_out();
        sb_entry_t   e;
        logic [16:0] obs;
        obs = {mem_rd, mem_wr, ir_load, pc_inc, pc_load, cbus_en, bbus_en, alu_op, busy, done, err};
        e = sb_q.pop_front();
        compared++;
        assert (obs === e.exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, check at negedge
    task automatic cyc(input string tag, input logic st, input logic rdy,
                       input logic z, input logic [16:0] exp);
        sb_entry_t e;
        start     = st;
        mem_ready = rdy;
        z_flag    = z;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(negedge clock);
        check_out();
        @(posedge clock);
        #1;
    endtask

    // FETCH with immediate mem_ready, then DECODE
    task automatic fd(input string nm, input logic [11:0] ins);
        instr = ins;
        cyc({nm, "_fetch"},  1'b0, 1'b1, 1'b0, ex(1,0,1,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        cyc({nm, "_decode"}, 1'b0, 1'b0, 1'b0, ex(0,0,0,1,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        z_flag    = 1'b0;
        instr     = 12'h000;
        @(posedge clock);
        #1;

        // Reset beats start; IDLE ignores mem_ready
        cyc("reset_beats_start", 1, 1, 0, 17'd0);
        reset = 1'b0;
        cyc("idle_after_reset",  0, 1, 0, 17'd0);
        cyc("idle_start",        1, 1, 0, 17'd0);

        // ALU instructions: three cycles each, mem_ready in EXEC ignored
        fd("add", 12'h244);
        cyc("add_exec", 0, 1, 0, ex(0,0,0,0,0, REG1_C, REG1_B, ALU_ADD, 1,0,0));
        fd("sub", 12'h321);
        cyc("sub_exec", 0, 1, 0, ex(0,0,0,0,0, 4'b0010, 3'b001, ALU_SUB, 1,0,0));
        fd("mov", 12'h156);
        cyc("mov_exec", 0, 1, 0, ex(0,0,0,0,0, 4'b0101, 3'b110, ALU_PASS, 1,0,0));
        fd("inc", 12'h477);
        cyc("inc_exec", 0, 1, 0, ex(0,0,0,0,0, 4'b0111, 3'b111, ALU_INC, 1,0,0));
        fd("nop", 12'h000);
        cyc("nop_exec", 0, 1, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));

        // LOAD with mem_ready delayed five cycles in MEM
        fd("load", 12'h540);
        cyc("load_exec", 0, 0, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        for (int i = 0; i < 5; i++)
            cyc("load_wait", 0, 0, 0, ex(1,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        cyc("load_ready", 0, 1, 0, ex(1,0,0,0,0, REG1_C, 3'b000, ALU_PASS, 1,0,0));

        // Conditional and unconditional jumps
        fd("jmpz0", 12'h804);
        cyc("jmpz0_exec", 0, 1, 0, ex(0,0,0,0,0, 4'b0000, REG1_B, ALU_PASS, 1,0,0));
        fd("jmpz1", 12'h804);
        cyc("jmpz1_exec", 0, 1, 1, ex(0,0,0,0,1, 4'b0000, REG1_B, ALU_PASS, 1,0,0));
        fd("jmp", 12'h705);
        cyc("jmp_exec", 0, 1, 0, ex(0,0,0,0,1, 4'b0000, 3'b101, ALU_PASS, 1,0,0));

        // STORE with two wait cycles
        fd("store", 12'h603);
        cyc("store_exec", 0, 0, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        for (int i = 0; i < 2; i++)
            cyc("store_wait", 0, 0, 0, ex(0,1,0,0,0, 4'b0000, 3'b011, ALU_PASS, 1,0,0));
        cyc("store_ready", 0, 1, 0, ex(0,1,0,0,0, 4'b0000, 3'b011, ALU_PASS, 1,0,0));

        // END: done pulses once, HALT ignores start
        fd("end", 12'hF00);
        cyc("halt_entry", 1, 1, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 0,1,0));
        cyc("halt_hold1", 1, 1, 0, 17'd0);
        cyc("halt_hold2", 1, 1, 0, 17'd0);
        reset = 1'b1;
        cyc("reset_in_halt", 0, 0, 0, 17'd0);
        reset = 1'b0;

        // FETCH timeout: 255 waiting cycles, then ERR held
        cyc("idle_start_to", 1, 0, 0, 17'd0);
        for (int i = 0; i < MEM_TIMEOUT; i++)
            cyc("fetch_wait", 0, 0, 0, ex(1,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        cyc("timeout_err", 1, 1, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 0,0,1));
        cyc("err_hold",    1, 1, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 0,0,1));
        reset = 1'b1;
        cyc("reset_in_err", 0, 0, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 0,0,1));
        reset = 1'b0;

        // mem_ready on the last allowed cycle still counts as success
        instr = 12'h000;
        cyc("idle_start_edge", 1, 0, 0, 17'd0);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++)
            cyc("fetch_wait_edge", 0, 0, 0, ex(1,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        cyc("fetch_ready_at_limit", 0, 1, 0, ex(1,0,1,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        cyc("edge_decode",          0, 0, 0, ex(0,0,0,1,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        cyc("edge_nop_exec",        0, 0, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));

        // Illegal opcode traps to ERR
        fd("illegal9", 12'h9FF);
        cyc("illegal_err", 0, 1, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 0,0,1));
        reset = 1'b1;
        cyc("reset_in_err2", 0, 0, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 0,0,1));
        reset = 1'b0;

        // Reset in the middle of a STORE MEM phase
        cyc("idle_start_st", 1, 1, 0, 17'd0);
        fd("store2", 12'h602);
        cyc("store2_exec", 0, 0, 0, ex(0,0,0,0,0, 4'b0000, 3'b000, ALU_PASS, 1,0,0));
        cyc("store2_wait", 0, 0, 0, ex(0,1,0,0,0, 4'b0000, 3'b010, ALU_PASS, 1,0,0));
        reset = 1'b1;
        cyc("store2_reset_cycle", 0, 0, 0, ex(0,1,0,0,0, 4'b0000, 3'b010, ALU_PASS, 1,0,0));
        reset = 1'b0;
        cyc("after_reset_idle",   0, 1, 0, 17'd0);
        cyc("idle_ignores_ready", 0, 1, 0, 17'd0);

        // Every queued expectation was consumed
        compared++;
        assert (sb_q.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
